// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/decode/execute control for the 8-bit CPU.
// Owns all PC advance/redirect strobes and latches opcode and operand bytes.
module fetch_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       mem_ready,
   input  logic [7:0] mem_data,
   input  logic       flag_z,
   input  logic       flag_c,
   output logic       mem_req,
   output logic       pc_en,
   output logic       pc_load,
   output logic [7:0] pc_target,
   output logic [7:0] ir,
   output logic [7:0] operand,
   output logic       alu_en,
   output logic       reg_we,
   output logic       imm_sel,
   output logic       retire,
   output logic       halted
);

   localparam logic [2:0] S_FETCH   = 3'd0;
   localparam logic [2:0] S_DECODE  = 3'd1;
   localparam logic [2:0] S_OPERAND = 3'd2;
   localparam logic [2:0] S_EXEC    = 3'd3;
   localparam logic [2:0] S_HALT    = 3'd4;

   logic [2:0] state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] operand_q, operand_d;

   logic [3:0] opc;
   logic       is_alu;
   logic       is_two;
   logic       is_hlt;

   assign opc    = ir_q[7:4];
   assign is_alu = (opc >= 4'h1) && (opc <= 4'h7);
   // 0x8..0xB (LDI, JMP, JZ, JC) all carry a second byte
   assign is_two = (opc[3:2] == 2'b10);
   assign is_hlt = (opc == 4'hF);

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      operand_d = operand_q;
      mem_req   = 1'b0;
      pc_en     = 1'b0;
      pc_load   = 1'b0;
      alu_en    = 1'b0;
      reg_we    = 1'b0;
      imm_sel   = 1'b0;
      retire    = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_d    = mem_data;
               pc_en   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_two)      state_d = S_OPERAND;
            else if (is_hlt) state_d = S_HALT;
            else             state_d = S_EXEC;
         end
         S_OPERAND: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               operand_d = mem_data;
               pc_en     = 1'b1;
               state_d   = S_EXEC;
            end
         end
         S_EXEC: begin
            retire  = 1'b1;
            state_d = S_FETCH;
            case (opc)
               4'h8: begin
                  reg_we  = 1'b1;
                  imm_sel = 1'b1;
               end
               4'h9: begin
                  pc_en   = 1'b1;
                  pc_load = 1'b1;
               end
               4'hA: begin
                  pc_en   = flag_z;
                  pc_load = flag_z;
               end
               4'hB: begin
                  pc_en   = flag_c;
                  pc_load = flag_c;
               end
               default: begin
                  alu_en = is_alu;
                  reg_we = is_alu;
               end
            endcase
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase

      // While rst is held the PC is cleared anyway; keep every strobe quiet
      if (rst) begin
         pc_en   = 1'b0;
         pc_load = 1'b0;
         alu_en  = 1'b0;
         reg_we  = 1'b0;
         imm_sel = 1'b0;
         retire  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         ir_q      <= 8'h00;
         operand_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         operand_q <= operand_d;
      end
   end

   assign ir        = ir_q;
   assign operand   = operand_q;
   assign pc_target = operand_q;
   assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small PC and byte memory
// around the DUT; each task checks one scenario cycle by cycle.
module tb_fetch_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mem_ready = 1'b0;
   logic [7:0] mem_data;
   logic       flag_z = 1'b0;
   logic       flag_c = 1'b0;
   logic       mem_req;
   logic       pc_en;
   logic       pc_load;
   logic [7:0] pc_target;
   logic [7:0] ir;
   logic [7:0] operand;
   logic       alu_en;
   logic       reg_we;
   logic       imm_sel;
   logic       retire;
   logic       halted;

   logic [7:0] mem [256];
   logic [7:0] pc;
   int errors = 0;
   int checks = 0;

   fetch_sequencer dut (
      .clk(clk), .rst(rst), .mem_ready(mem_ready),
      .mem_data(mem_data), .flag_z(flag_z), .flag_c(flag_c),
      .mem_req(mem_req), .pc_en(pc_en), .pc_load(pc_load),
      .pc_target(pc_target), .ir(ir), .operand(operand),
      .alu_en(alu_en), .reg_we(reg_we), .imm_sel(imm_sel),
      .retire(retire), .halted(halted)
   );

   always #5 clk = ~clk;

   assign mem_data = mem[pc];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        pc <= 8'h00;
      else if (pc_en) pc <= pc_load ? pc_target : pc + 8'd1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      mem_ready = 1'b0;
      flag_z = 1'b0;
      flag_c = 1'b0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      clear_mem;
      rst = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mem_req got=%b exp=1", mem_req); end
      checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL rst_pc_en got=%b exp=0", pc_en); end
      checks++; if (retire !== 1'b0) begin errors++; $display("FAIL rst_retire got=%b exp=0", retire); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got=%b exp=0", halted); end
      checks++; if (ir !== 8'h00) begin errors++; $display("FAIL rst_ir got=%h exp=00", ir); end
      checks++; if (operand !== 8'h00) begin errors++; $display("FAIL rst_operand got=%h exp=00", operand); end
      do_reset;
   endtask

   task automatic test_alu_op;
      clear_mem;
      mem[0] = 8'h10;
      do_reset;
      mem_ready = 1'b1;
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL alu_c0_mem_req got=%b exp=1", mem_req); end
      checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL alu_c0_pc_en got=%b exp=1", pc_en); end
      checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL alu_c0_pc_load got=%b exp=0", pc_load); end
      tick;
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL alu_c1_mem_req got=%b exp=0", mem_req); end
      checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL alu_c1_pc_en got=%b exp=0", pc_en); end
      checks++; if (ir !== 8'h10) begin errors++; $display("FAIL alu_c1_ir got=%h exp=10", ir); end
      tick;
      @(negedge clk);
      checks++; if (alu_en !== 1'b1) begin errors++; $display("FAIL alu_c2_alu_en got=%b exp=1", alu_en); end
      checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL alu_c2_reg_we got=%b exp=1", reg_we); end
      checks++; if (retire !== 1'b1) begin errors++; $display("FAIL alu_c2_retire got=%b exp=1", retire); end
      checks++; if (imm_sel !== 1'b0) begin errors++; $display("FAIL alu_c2_imm_sel got=%b exp=0", imm_sel); end
      tick;
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL alu_c3_mem_req got=%b exp=1", mem_req); end
      checks++; if (pc !== 8'h01) begin errors++; $display("FAIL alu_c3_pc got=%h exp=01", pc); end
   endtask

   task automatic test_ldi_wait;
      logic [7:0] rdy_t;
      logic [7:0] req_t;
      logic [7:0] ex_t;
      rdy_t = 8'b0100_0100;
      req_t = 8'b0111_0111;
      ex_t  = 8'b1000_0000;
      clear_mem;
      mem[0] = 8'h80;
      mem[1] = 8'h5A;
      do_reset;
      for (int c = 0; c < 8; c++) begin
         mem_ready = rdy_t[c];
         @(negedge clk);
         checks++; if (mem_req !== req_t[c]) begin errors++; $display("FAIL ldi_c%0d_mem_req got=%b exp=%b", c, mem_req, req_t[c]); end
         checks++; if (pc_en !== rdy_t[c]) begin errors++; $display("FAIL ldi_c%0d_pc_en got=%b exp=%b", c, pc_en, rdy_t[c]); end
         checks++; if (reg_we !== ex_t[c]) begin errors++; $display("FAIL ldi_c%0d_reg_we got=%b exp=%b", c, reg_we, ex_t[c]); end
         checks++; if (imm_sel !== ex_t[c]) begin errors++; $display("FAIL ldi_c%0d_imm_sel got=%b exp=%b", c, imm_sel, ex_t[c]); end
         checks++; if (retire !== ex_t[c]) begin errors++; $display("FAIL ldi_c%0d_retire got=%b exp=%b", c, retire, ex_t[c]); end
         tick;
      end
      mem_ready = 1'b0;
      @(negedge clk);
      checks++; if (operand !== 8'h5A) begin errors++; $display("FAIL ldi_operand got=%h exp=5a", operand); end
      checks++; if (pc !== 8'h02) begin errors++; $display("FAIL ldi_pc got=%h exp=02", pc); end
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ldi_c8_mem_req got=%b exp=1", mem_req); end
   endtask

   task automatic test_jump;
      int loads;
      // JMP 0x40
      clear_mem;
      mem[0] = 8'h90;
      mem[1] = 8'h40;
      do_reset;
      mem_ready = 1'b1;
      loads = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (pc_load === 1'b1) loads++;
         if (c == 3) begin
            checks++; if (pc_target !== 8'h40) begin errors++; $display("FAIL jmp_target got=%h exp=40", pc_target); end
            checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL jmp_pc_en got=%b exp=1", pc_en); end
         end
         tick;
      end
      checks++; if (loads !== 1) begin errors++; $display("FAIL jmp_load_cycles got=%0d exp=1", loads); end
      @(negedge clk);
      checks++; if (pc !== 8'h40) begin errors++; $display("FAIL jmp_next_pc got=%h exp=40", pc); end
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL jmp_next_req got=%b exp=1", mem_req); end
      // JZ not taken; flag_z high only in DECODE
      clear_mem;
      mem[0] = 8'hA0;
      mem[1] = 8'h40;
      do_reset;
      mem_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         flag_z = (c == 1);
         @(negedge clk);
         if (c == 3) begin
            checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL jz_pc_load got=%b exp=0", pc_load); end
            checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL jz_pc_en got=%b exp=0", pc_en); end
            checks++; if (retire !== 1'b1) begin errors++; $display("FAIL jz_retire got=%b exp=1", retire); end
         end
         tick;
      end
      @(negedge clk);
      checks++; if (pc !== 8'h02) begin errors++; $display("FAIL jz_next_pc got=%h exp=02", pc); end
      // JC taken
      clear_mem;
      mem[0] = 8'hB0;
      mem[1] = 8'h33;
      do_reset;
      mem_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         flag_c = (c == 3);
         tick;
      end
      flag_c = 1'b0;
      @(negedge clk);
      checks++; if (pc !== 8'h33) begin errors++; $display("FAIL jc_next_pc got=%h exp=33", pc); end
   endtask

   task automatic test_wrap;
      // single-byte op at 0xFF
      clear_mem;
      mem[0] = 8'h90;
      mem[1] = 8'hFF;
      mem[8'hFF] = 8'h10;
      do_reset;
      mem_ready = 1'b1;
      for (int c = 0; c < 4; c++) tick;
      @(negedge clk);
      checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL wrap_at_ff got=%h exp=ff", pc); end
      checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL wrap_pc_en got=%b exp=1", pc_en); end
      for (int c = 0; c < 3; c++) tick;
      @(negedge clk);
      checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wrap_pc got=%h exp=00", pc); end
      // LDI at 0xFF takes its operand from 0x00
      mem[8'hFF] = 8'h80;
      do_reset;
      mem_ready = 1'b1;
      for (int c = 0; c < 7; c++) tick;
      @(negedge clk);
      checks++; if (operand !== 8'h90) begin errors++; $display("FAIL wrap_ldi_operand got=%h exp=90", operand); end
      checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL wrap_ldi_reg_we got=%b exp=1", reg_we); end
      tick;
      @(negedge clk);
      checks++; if (pc !== 8'h01) begin errors++; $display("FAIL wrap_ldi_pc got=%h exp=01", pc); end
   endtask

   task automatic test_halt;
      clear_mem;
      mem[0] = 8'hF0;
      do_reset;
      mem_ready = 1'b1;
      @(negedge clk);
      tick;
      @(negedge clk);
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hlt_decode_halted got=%b exp=0", halted); end
      tick;
      for (int c = 0; c < 20; c++) begin
         mem_ready = c[0];
         @(negedge clk);
         checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hlt_c%0d_halted got=%b exp=1", c, halted); end
         checks++; if ({mem_req, pc_en, retire} !== 3'b000) begin errors++; $display("FAIL hlt_c%0d_strobes got=%b exp=000", c, {mem_req, pc_en, retire}); end
         tick;
      end
      do_reset;
      @(negedge clk);
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hlt_rst_halted got=%b exp=0", halted); end
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL hlt_rst_mem_req got=%b exp=1", mem_req); end
   endtask

   task automatic test_reset_mid;
      clear_mem;
      mem[0] = 8'h90;
      mem[1] = 8'h40;
      do_reset;
      mem_ready = 1'b1;
      tick;
      tick;
      mem_ready = 1'b0;
      @(negedge clk);
      checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL mid_wait_pc_en got=%b exp=0", pc_en); end
      rst = 1'b1;
      #1;
      checks++; if ({pc_en, pc_load, retire} !== 3'b000) begin errors++; $display("FAIL mid_rst_strobes got=%b exp=000", {pc_en, pc_load, retire}); end
      checks++; if (ir !== 8'h00) begin errors++; $display("FAIL mid_rst_ir got=%h exp=00", ir); end
      checks++; if (operand !== 8'h00) begin errors++; $display("FAIL mid_rst_operand got=%h exp=00", operand); end
      tick;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_rel_mem_req got=%b exp=1", mem_req); end
      checks++; if ({pc_load, retire} !== 2'b00) begin errors++; $display("FAIL mid_rel_strobes got=%b exp=00", {pc_load, retire}); end
      checks++; if (ir !== 8'h00) begin errors++; $display("FAIL mid_rel_ir got=%h exp=00", ir); end
      checks++; if (pc !== 8'h00) begin errors++; $display("FAIL mid_rel_pc got=%h exp=00", pc); end
   endtask

   initial begin
      clear_mem;
      test_reset;
      test_alu_op;
      test_ldi_wait;
      test_jump;
      test_wrap;
      test_halt;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle control sequencer for the 8-bit CPU. It drives the program counter's `en`/`load` strobes and a byte-wide memory read handshake, and it latches the opcode and operand bytes. It also issues one-cycle execute strobes to the register file and ALU. It sits between instruction memory, the PC and the datapath, and is the only block that advances or redirects the PC.

## Interface
Parameters: none; all widths are 8 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_ready  in  1  memory has valid data on `mem_data` this cycle
- mem_data  in  8  byte read at the current PC
- flag_z  in  1  ALU zero flag, sampled in EXEC
- flag_c  in  1  ALU carry flag, sampled in EXEC
- mem_req  out  1  read request; address is the PC output
- pc_en  out  1  to PC `en`
- pc_load  out  1  to PC `load`
- pc_target  out  8  to PC `next`; equals the operand register
- ir  out  8  latched opcode byte
- operand  out  8  latched second byte (immediate or jump target)
- alu_en  out  1  ALU operation strobe
- reg_we  out  1  register-file write strobe
- imm_sel  out  1  write data comes from `operand` (LDI), not from the ALU
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  high while in HALT

## Operation
- States: FETCH, DECODE, OPERAND, EXEC, HALT. The state register, `ir` and `operand` are registered. All other outputs are combinational from state, inputs and `ir`.
- Opcode class is `ir[7:4]`:
  - 0x0 NOP
  - 0x1–0x7 ALU op: single byte
  - 0x8 LDI: two bytes
  - 0x9 JMP: two bytes
  - 0xA JZ: two bytes
  - 0xB JC: two bytes
  - 0xF HLT
  - 0xC–0xE: executed as NOP
- FETCH: `mem_req`=1.
  - If `mem_ready`=1: `ir`<=`mem_data`, `pc_en`=1 (PC increments at the same edge), next state DECODE.
  - Otherwise remain in FETCH with `mem_req` held high.
- DECODE: no strobes.
  - Next state is OPERAND for 0x8–0xB.
  - Next state is HALT for 0xF.
  - Next state is EXEC otherwise.
- OPERAND: `mem_req`=1.
  - On `mem_ready`: `operand`<=`mem_data`, `pc_en`=1, next state EXEC.
  - Otherwise wait.
- EXEC: always one cycle, `retire`=1, next state FETCH.
  - ALU op: `alu_en`=1, `reg_we`=1.
  - LDI: `reg_we`=1, `imm_sel`=1.
  - JMP: `pc_en`=1, `pc_load`=1.
  - JZ: `pc_en`=`pc_load`=`flag_z`.
  - JC: `pc_en`=`pc_load`=`flag_c`.
  - NOP and undefined opcodes: `retire` only.
- HALT: `halted`=1; all other strobes 0. HALT is terminal until `rst`.
- `mem_ready` is ignored outside FETCH and OPERAND.
- `pc_en`/`pc_load` are never asserted in DECODE or HALT.
- `pc_load` is never asserted without `pc_en`.

## Timing
- Reset values: state=FETCH, `ir`=0x00, `operand`=0x00, `halted`=0. All strobes and `retire` are 0, except `mem_req`=1 in FETCH.
- Reset mid-instruction aborts it: no `retire`, no PC strobe. The first fetch occurs on the first cycle after `rst` deasserts; the PC is reset by the same `rst`.
- Latency with zero wait states:
  - Single-byte instruction: 3 cycles (FETCH, DECODE, EXEC).
  - Two-byte instruction: 4 cycles.
  - Each wait cycle adds one cycle to FETCH or OPERAND.
- A taken jump loads the PC at the EXEC edge; the next FETCH reads from `pc_target`.
- A not-taken JZ/JC leaves the PC pointing at the byte after the operand.
- PC wrap: an opcode at 0xFF puts its operand at 0x00. The sequencer adds no special handling; the PC wraps.
- A jump to its own address is legal and loops indefinitely.
- `flag_z`/`flag_c` are sampled only in EXEC; flag changes in other states have no effect.

## Test plan
- Reset then zero-wait program 0x10 at 0x00: `mem_req` high in cycle 0; `pc_en` in cycle 0; `alu_en`, `reg_we` and `retire` in cycle 2; FETCH again in cycle 3 with PC=0x01.
- LDI 0x80,0x5A with 2 wait cycles on each byte: `operand`=0x5A; `reg_we`+`imm_sel` in EXEC; total 8 cycles; PC=0x02 afterwards.
- JMP 0x90,0x40: `pc_target`=0x40, `pc_en`=`pc_load`=1 for exactly one cycle; next fetch address 0x40. JZ 0xA0,0x40 with `flag_z`=0: no `pc_load`; PC=0x02 at the next FETCH.
- Opcode 0x10 placed at 0xFF: `pc_en` wraps PC to 0x00. LDI at 0xFF: operand fetched from 0x00, next fetch from 0x01.
- HLT 0xF0: `halted`=1 from the cycle after DECODE; `mem_req`, `pc_en` and `retire` stay 0 for 20 cycles with `mem_ready` toggling. `rst` clears `halted` and restarts at FETCH.
- `rst` asserted in OPERAND of a JMP: no `pc_load` or `retire`. After release, state=FETCH, `ir`=0x00 and `operand`=0x00.
